// File: rtl/parking_lot_tracker.sv
// Multi-lane car enter/exit detector feeding a saturating lot occupancy counter.
// Latency: enter/exit/seq_err pulses and occupancy/flags update one edge after the completing sample.
// Backpressure: none; sensors are sampled every cycle and the counter clamps instead of stalling.
module parking_lot_tracker #(
    parameter  int LANES    = 2,
    parameter  int CAPACITY = 16,
    localparam int CNT_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LANES-1:0] a,
    input  logic [LANES-1:0] b,
    input  logic             clear,
    output logic [LANES-1:0] enter,
    output logic [LANES-1:0] exit,
    output logic [LANES-1:0] seq_err,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    // Width of a per-cycle event count (0..LANES).
    localparam int PW = $clog2(LANES + 1);
    // Signed working width for occupancy +/- event counts; one spare bit so
    // neither a negative result nor a sum above CAPACITY can wrap.
    localparam int SW = CNT_W + PW + 1;

    localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);

    // EN* track a car moving outer->inner (a first); EX* track inner->outer.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EN1  = 3'd1,  // a only
        EN2  = 3'd2,  // a and b
        EN3  = 3'd3,  // b only, waiting for clearance
        EX1  = 3'd4,  // b only
        EX2  = 3'd5,  // a and b
        EX3  = 3'd6   // a only, waiting for clearance
    } lane_state_t;

    lane_state_t state      [LANES];
    lane_state_t state_next [LANES];

    logic [LANES-1:0] enter_next;
    logic [LANES-1:0] exit_next;
    logic [LANES-1:0] seq_err_next;

    logic [PW-1:0]          n_enter;
    logic [PW-1:0]          n_exit;
    logic signed [SW-1:0]   occ_sum;
    logic [CNT_W-1:0]       occ_next;
    logic                   overflow_next;
    logic                   underflow_next;

    // Per-lane next-state and event decode from the current {a,b} sample.
    always_comb begin
        enter_next   = '0;
        exit_next    = '0;
        seq_err_next = '0;
        for (int i = 0; i < LANES; i++) begin
            state_next[i] = state[i];
            case (state[i])
                IDLE: begin
                    case ({a[i], b[i]})
                        2'b10:   state_next[i] = EN1;
                        2'b01:   state_next[i] = EX1;
                        2'b11:   seq_err_next[i] = 1'b1;
                        default: state_next[i] = IDLE;
                    endcase
                end
                EN1: begin
                    case ({a[i], b[i]})
                        2'b11:   state_next[i] = EN2;
                        2'b10:   state_next[i] = EN1;
                        2'b01: begin
                            state_next[i]   = IDLE;
                            seq_err_next[i] = 1'b1;
                        end
                        default: state_next[i] = IDLE;
                    endcase
                end
                EN2: begin
                    case ({a[i], b[i]})
                        2'b11:   state_next[i] = EN2;
                        2'b10:   state_next[i] = EN1;
                        2'b01:   state_next[i] = EN3;
                        default: begin
                            state_next[i]   = IDLE;
                            seq_err_next[i] = 1'b1;
                        end
                    endcase
                end
                EN3: begin
                    case ({a[i], b[i]})
                        2'b01:   state_next[i] = EN3;
                        2'b11:   state_next[i] = EN2;
                        2'b00: begin
                            state_next[i] = IDLE;
                            enter_next[i] = 1'b1;
                        end
                        default: begin
                            state_next[i]   = IDLE;
                            seq_err_next[i] = 1'b1;
                        end
                    endcase
                end
                EX1: begin
                    case ({a[i], b[i]})
                        2'b11:   state_next[i] = EX2;
                        2'b01:   state_next[i] = EX1;
                        2'b10: begin
                            state_next[i]   = IDLE;
                            seq_err_next[i] = 1'b1;
                        end
                        default: state_next[i] = IDLE;
                    endcase
                end
                EX2: begin
                    case ({a[i], b[i]})
                        2'b11:   state_next[i] = EX2;
                        2'b01:   state_next[i] = EX1;
                        2'b10:   state_next[i] = EX3;
                        default: begin
                            state_next[i]   = IDLE;
                            seq_err_next[i] = 1'b1;
                        end
                    endcase
                end
                EX3: begin
                    case ({a[i], b[i]})
                        2'b10:   state_next[i] = EX3;
                        2'b11:   state_next[i] = EX2;
                        2'b00: begin
                            state_next[i] = IDLE;
                            exit_next[i]  = 1'b1;
                        end
                        default: begin
                            state_next[i]   = IDLE;
                            seq_err_next[i] = 1'b1;
                        end
                    endcase
                end
                default: state_next[i] = IDLE;
            endcase
        end
    end

    // Merge all lanes into one net occupancy change, then clamp to [0, CAPACITY].
    always_comb begin
        n_enter = '0;
        n_exit  = '0;
        for (int i = 0; i < LANES; i++) begin
            n_enter = n_enter + PW'(enter_next[i]);
            n_exit  = n_exit  + PW'(exit_next[i]);
        end
        occ_sum = $signed({{(SW-CNT_W){1'b0}}, occupancy})
                + $signed({{(SW-PW){1'b0}}, n_enter})
                - $signed({{(SW-PW){1'b0}}, n_exit});

        overflow_next  = 1'b0;
        underflow_next = 1'b0;
        if (clear) begin
            // Clear wins; any events on this edge are reported but not counted.
            occ_next = '0;
        end else if (occ_sum > CAP_S) begin
            occ_next      = CNT_W'(CAPACITY);
            overflow_next = 1'b1;
        end else if (occ_sum < 0) begin
            occ_next       = '0;
            underflow_next = 1'b1;
        end else begin
            occ_next = CNT_W'(occ_sum);
        end
    end

    // Lane FSM state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                state[i] <= IDLE;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                state[i] <= state_next[i];
            end
        end
    end

    // Event pulses and counter status, all registered together so they agree.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter     <= '0;
            exit      <= '0;
            seq_err   <= '0;
            occupancy <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            enter     <= enter_next;
            exit      <= exit_next;
            seq_err   <= seq_err_next;
            occupancy <= occ_next;
            full      <= (occ_next == CNT_W'(CAPACITY));
            empty     <= (occ_next == '0);
            overflow  <= overflow_next;
            underflow <= underflow_next;
        end
    end

endmodule

// File: tb/tb_parking_lot_tracker.sv
// Directed bench for parking_lot_tracker with two lanes and a capacity of three.
// Latency: each step applies one sensor sample and checks outputs 1 time unit after the edge.
// Backpressure: not applicable; stimulus advances one clock per step.
module tb_parking_lot_tracker;

    localparam int LANES    = 2;
    localparam int CAPACITY = 3;
    localparam int CNT_W    = $clog2(CAPACITY + 1);

    logic             clk;
    logic             reset;
    logic [LANES-1:0] a;
    logic [LANES-1:0] b;
    logic             clear;
    logic [LANES-1:0] enter;
    logic [LANES-1:0] exit;
    logic [LANES-1:0] seq_err;
    logic [CNT_W-1:0] occupancy;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    int n_assert = 0;
    int n_fail   = 0;

    parking_lot_tracker #(
        .LANES    (LANES),
        .CAPACITY (CAPACITY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .clear     (clear),
        .enter     (enter),
        .exit      (exit),
        .seq_err   (seq_err),
        .occupancy (occupancy),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one sample per lane, given as {a,b}, and advance past the next edge.
    task automatic step(input logic [1:0] ab0, input logic [1:0] ab1);
        a = {ab1[1], ab0[1]};
        b = {ab1[0], ab0[0]};
        @(posedge clk);
        #1;
    endtask

    // Full clean car passage on one lane; outputs of the completing edge are visible afterwards.
    task automatic car(input int lane, input bit is_exit);
        logic [1:0] s [4];
        if (is_exit) s = '{2'b01, 2'b11, 2'b10, 2'b00};
        else         s = '{2'b10, 2'b11, 2'b01, 2'b00};
        for (int k = 0; k < 4; k++) begin
            if (lane == 0) step(s[k], 2'b00);
            else           step(2'b00, s[k]);
        end
    endtask

    initial begin
        reset = 1'b0;
        a     = '0;
        b     = '0;
        clear = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_occ",   occupancy, 0);
        chk("rst_empty", empty,     1);
        chk("rst_full",  full,      0);
        chk("rst_enter", enter,     0);
        chk("rst_exit",  exit,      0);
        chk("rst_err",   seq_err,   0);
        chk("rst_ovf",   overflow,  0);
        chk("rst_unf",   underflow, 0);
        reset = 1'b1;

        // Lane 0 entry: pulse only after the 00 edge.
        step(2'b10, 2'b00);
        step(2'b11, 2'b00);
        step(2'b01, 2'b00);
        chk("t1_enter_early", enter, 0);
        chk("t1_occ_early",   occupancy, 0);
        step(2'b00, 2'b00);
        chk("t1_enter", enter, 2'b01);
        chk("t1_occ",   occupancy, 1);
        chk("t1_empty", empty, 0);
        step(2'b00, 2'b00);
        chk("t1_enter_gone", enter, 0);
        chk("t1_occ_hold",   occupancy, 1);

        // Lane 1 exit to empty, then a further exit clamps at 0.
        car(1, 1);
        chk("t2_exit",  exit, 2'b10);
        chk("t2_occ",   occupancy, 0);
        chk("t2_empty", empty, 1);
        chk("t2_unf0",  underflow, 0);
        car(1, 1);
        chk("t2_exit2", exit, 2'b10);
        chk("t2_occ2",  occupancy, 0);
        chk("t2_unf",   underflow, 1);
        step(2'b00, 2'b00);
        chk("t2_unf_gone", underflow, 0);

        // Fill to 2, then double entry saturates at capacity.
        car(0, 0);
        car(0, 0);
        chk("t3_occ2", occupancy, 2);
        step(2'b10, 2'b10);
        step(2'b11, 2'b11);
        step(2'b01, 2'b01);
        step(2'b00, 2'b00);
        chk("t3_enter_both", enter, 2'b11);
        chk("t3_occ_sat",    occupancy, 3);
        chk("t3_full",       full, 1);
        chk("t3_ovf",        overflow, 1);
        // Simultaneous enter on lane 0 and exit on lane 1 nets to zero.
        step(2'b10, 2'b01);
        step(2'b11, 2'b11);
        step(2'b01, 2'b10);
        step(2'b00, 2'b00);
        chk("t3_mix_enter", enter, 2'b01);
        chk("t3_mix_exit",  exit, 2'b10);
        chk("t3_mix_occ",   occupancy, 3);
        chk("t3_mix_ovf",   overflow, 0);
        chk("t3_mix_unf",   underflow, 0);
        chk("t3_mix_full",  full, 1);

        // Reversal mid-entry still yields one enter; aborted exit yields nothing.
        car(1, 1);
        chk("t4_occ2", occupancy, 2);
        step(2'b10, 2'b00);
        step(2'b11, 2'b00);
        step(2'b10, 2'b00);
        step(2'b11, 2'b00);
        step(2'b01, 2'b00);
        chk("t4_no_early", enter, 0);
        step(2'b00, 2'b00);
        chk("t4_enter", enter, 2'b01);
        chk("t4_occ3",  occupancy, 3);
        step(2'b01, 2'b00);
        step(2'b11, 2'b00);
        step(2'b10, 2'b00);
        step(2'b11, 2'b00);
        step(2'b01, 2'b00);
        step(2'b00, 2'b00);
        chk("t4_abort_exit", exit, 0);
        chk("t4_abort_err",  seq_err, 0);
        chk("t4_abort_occ",  occupancy, 3);

        // Illegal sequences on both lanes.
        step(2'b11, 2'b10);
        chk("t5_err0", seq_err, 2'b01);
        step(2'b00, 2'b01);
        chk("t5_err1", seq_err, 2'b10);
        chk("t5_occ",  occupancy, 3);
        step(2'b00, 2'b00);
        chk("t5_err_gone", seq_err, 0);
        car(1, 1);
        chk("t5_idle_exit", exit, 2'b10);
        chk("t5_occ2",      occupancy, 2);

        // Asynchronous reset while lane 0 is mid-entry.
        step(2'b10, 2'b00);
        step(2'b11, 2'b00);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rst_occ",   occupancy, 0);
        chk("t6_rst_empty", empty, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(2'b01, 2'b00);
        step(2'b00, 2'b00);
        chk("t6_no_enter", enter, 0);
        chk("t6_no_err",   seq_err, 0);
        chk("t6_occ0",     occupancy, 0);

        // Clear coincident with an entry: pulse fires, occupancy goes to 0.
        car(0, 0);
        chk("t6_occ1", occupancy, 1);
        step(2'b10, 2'b00);
        step(2'b11, 2'b00);
        step(2'b01, 2'b00);
        clear = 1'b1;
        step(2'b00, 2'b00);
        clear = 1'b0;
        chk("t6_clr_enter", enter, 2'b01);
        chk("t6_clr_occ",   occupancy, 0);
        chk("t6_clr_empty", empty, 1);
        chk("t6_clr_ovf",   overflow, 0);
        chk("t6_clr_unf",   underflow, 0);
        step(2'b00, 2'b00);
        chk("t6_after_clr", occupancy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
